// File: rtl/mem_copy_dma_pkg.sv
// Shared state encoding and address constants for the memory-copy DMA.
package mem_copy_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } dma_state_t;

  localparam int unsigned IO_BASE = 248;

endpackage

// File: rtl/mem_copy_dma.sv
// Word-at-a-time memory copy engine: READ then WRITE per word, one-cycle DONE pulse.
// Optional fill mode (write a constant, one word per cycle) enabled by macro DMA_FILL_EN.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC,
  input  logic [ADDR_W-1:0] DST,
  input  logic [7:0]        LEN,
`ifdef DMA_FILL_EN
  input  logic              FILL,
  input  logic [DATA_W-1:0] FILL_VAL,
`endif
  input  logic [DATA_W-1:0] Q,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DATA,
  output logic              MW,
  output logic              BUSY,
  output logic              DONE
);

  dma_state_t        r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_buf;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mw;
  logic              r_busy;
  logic              r_done;
`ifdef DMA_FILL_EN
  logic              r_fill;
`endif

  // Outputs are registered one state ahead, so each transition also loads the next state's bus values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_mw    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DMA_FILL_EN
      r_fill  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_addr <= '0;
          r_mw   <= 1'b0;
          r_done <= 1'b0;
          if (START) begin
            r_busy <= 1'b1;
            if (LEN == 8'd0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_src <= SRC;
              r_dst <= DST;
              r_cnt <= LEN;
`ifdef DMA_FILL_EN
              r_fill <= FILL;
              if (FILL) begin
                r_state <= S_WRITE;
                r_addr  <= DST;
                r_buf   <= FILL_VAL;
                r_mw    <= 1'b1;
              end else begin
                r_state <= S_READ;
                r_addr  <= SRC;
              end
`else
              r_state <= S_READ;
              r_addr  <= SRC;
`endif
            end
          end
        end
        S_READ: begin
          r_buf   <= Q;
          r_state <= S_WRITE;
          r_addr  <= r_dst;
          r_mw    <= 1'b1;
        end
        S_WRITE: begin
          r_src <= r_src + ADDR_W'(1);
          r_dst <= r_dst + ADDR_W'(1);
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state <= S_FIN;
            r_addr  <= '0;
            r_mw    <= 1'b0;
            r_done  <= 1'b1;
`ifdef DMA_FILL_EN
          end else if (r_fill) begin
            r_state <= S_WRITE;
            r_addr  <= r_dst + ADDR_W'(1);
            r_mw    <= 1'b1;
`endif
          end else begin
            r_state <= S_READ;
            r_addr  <= r_src + ADDR_W'(1);
            r_mw    <= 1'b0;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_addr  <= '0;
          r_mw    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ADDR = r_addr;
  assign DATA = r_mw ? r_buf : '0;
  assign MW   = r_mw;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule
